// File: rtl/car_pattern_gen.sv
// Car pattern generator: builds one LFSR-derived, density-shaped pattern per lane,
// guarantees a passable zero gap, strobes each into its lane, then paces the scroll tick.
module car_pattern_gen #(
    parameter int          WIDTH     = 16,
    parameter int          LANES     = 4,
    parameter int          GAP_MIN   = 3,
    parameter int          MAX_RETRY = 8,
    parameter int          TICK_DIV  = 25_000_000,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 level,
    output logic [WIDTH-1:0]           pattern_out,
    output logic [$clog2(LANES)-1:0]   lane_sel,
    output logic                       pattern_valid,
    output logic                       shift_en,
    output logic                       busy,
    output logic                       done
);

    localparam int LW = $clog2(LANES);
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [15:0]   TAPS       = 16'hB400;
    localparam logic [LW-1:0] LAST_LANE  = LW'(LANES - 1);
    localparam logic [RW-1:0] LAST_RETRY = RW'(MAX_RETRY - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_CHECK,
        S_EMIT,
        S_RUN
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? TAPS : 16'h0000);
    endfunction

    // Maps the 16-bit LFSR word onto WIDTH columns, repeating it if the road is wider.
    function automatic logic [WIDTH-1:0] fit(input logic [15:0] n);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = n[i % 16];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int unsigned k);
        return (v >> k) | (v << (WIDTH - k));
    endfunction

    function automatic logic [WIDTH-1:0] shape(input logic [WIDTH-1:0] n, input logic [1:0] lvl);
        logic [WIDTH-1:0] r;
        unique case (lvl)
            2'd0:    r = n & rotr(n, 3) & rotr(n, 7);
            2'd1:    r = n & rotr(n, 5);
            2'd2:    r = n;
            default: r = n | rotr(n, 4);
        endcase
        return r;
    endfunction

    // Scanning the pattern twice end-to-end catches runs that wrap past bit 0.
    function automatic int longest_zero_run(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] dd;
        int run;
        int best;
        dd   = {v, v};
        run  = 0;
        best = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (!dd[i]) begin
                run = run + 1;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        if (best > WIDTH) best = WIDTH;
        return best;
    endfunction

    function automatic logic [WIDTH-1:0] low_mask();
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i < GAP_MIN);
        end
        return m;
    endfunction

    localparam logic [WIDTH-1:0] FORCE_MASK = low_mask();

    state_e           state_q,   state_d;
    logic [15:0]      lfsr_q,    lfsr_d;
    logic [WIDTH-1:0] cand_q,    cand_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [LW-1:0]    lane_q,    lane_d;
    logic [RW-1:0]    retry_q,   retry_d;
    logic [TW-1:0]    tick_q,    tick_d;

    logic [15:0]      lfsr_n;
    logic [WIDTH-1:0] shaped;
    logic             gap_ok;

    assign lfsr_n = lfsr_next(lfsr_q);
    assign shaped = shape(fit(lfsr_n), level);
    assign gap_ok = (longest_zero_run(cand_q) >= GAP_MIN);

    // NOTE: every register here is a few bits of control or datapath, so all of them take the
    // async reset; clocked state is written with <= so each edge sees only pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED;
            cand_q    <= '0;
            pattern_q <= '0;
            lane_q    <= '0;
            retry_q   <= '0;
            tick_q    <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cand_q    <= cand_d;
            pattern_q <= pattern_d;
            lane_q    <= lane_d;
            retry_q   <= retry_d;
            tick_q    <= tick_d;
        end
    end

    // NOTE: every _d starts as its _q so no path through the case leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cand_d    = cand_q;
        pattern_d = pattern_q;
        lane_d    = lane_q;
        retry_d   = retry_q;
        tick_d    = tick_q;

        unique case (state_q)
            S_IDLE: begin
                lane_d  = '0;
                retry_d = '0;
                if (start) state_d = S_GEN;
            end
            S_GEN: begin
                lfsr_d  = lfsr_n;
                cand_d  = shaped;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (gap_ok) begin
                    pattern_d = cand_q;
                    state_d   = S_EMIT;
                end else if (retry_q != LAST_RETRY) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_GEN;
                end else begin
                    // Out of retries: carve the gap into the low columns.
                    pattern_d = cand_q & ~FORCE_MASK;
                    state_d   = S_EMIT;
                end
            end
            S_EMIT: begin
                retry_d = '0;
                if (lane_q == LAST_LANE) begin
                    lane_d  = '0;
                    tick_d  = '0;
                    state_d = S_RUN;
                end else begin
                    lane_d  = lane_q + LW'(1);
                    state_d = S_GEN;
                end
            end
            S_RUN: begin
                if (start) begin
                    lane_d  = '0;
                    state_d = S_GEN;
                end else begin
                    tick_d = (tick_q == LAST_TICK) ? '0 : tick_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pattern_out   = pattern_q;
        lane_sel      = lane_q;
        pattern_valid = (state_q == S_EMIT);
        done          = (state_q == S_EMIT) && (lane_q == LAST_LANE);
        busy          = (state_q == S_GEN) || (state_q == S_CHECK) || (state_q == S_EMIT);
        shift_en      = (state_q == S_RUN) && (tick_q == LAST_TICK);
    end

endmodule
